// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display.
//   digit_t     : one BCD digit (values 10-15 show a dash)
//   seg_t       : active-low segments {g,f,e,d,c,b,a}
//   SEG_DASH    : only segment g lit
//   SEG_OFF     : all segments dark
//   ANODE_TBL   : active-low digit enable per scan index (index 0 = A = an[3])
package disp_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Packed so entry [0] is the rightmost literal: index 0 enables A.
  localparam logic [3:0][3:0] ANODE_TBL = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder.
//   digit_i : 4-bit value
//   seg_o   : active-low segments {g,f,e,d,c,b,a}; 10-15 decode to a dash
module seg7_decode
  import disp_pkg::*;
(
  input  digit_t digit_i,
  output seg_t   seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (digit_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_display_scan.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Parameters:
//   REFRESH_DIV  : clk cycles per digit slot (>= 2)
//   BLINK_FRAMES : full frames per blink half-period (>= 1)
// Ports:
//   clk, reset (synchronous, active-low)
//   A,B,C,D    : BCD digits, A leftmost; captured into shadow registers on load
//   dp_mask    : decimal-point enables, bit 3 = A .. bit 0 = D
//   blink_mask : per-digit blink request, same bit order
//   seg, dp, an: registered active-low segment, decimal point and digit enables
//   frame_done : one-cycle pulse after the last slot of each frame
// Build option: define DISP_BLINK_EN to build the blink counter/phase; without
// it blink_mask is ignored.
module digit_display_scan
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic       load,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blink_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  digit_t [3:0]     shadow_q, shadow_d;
  seg_t             seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;
  logic             fd_q, fd_d;

  logic       tick;
  logic       frame_wrap;
  logic       blink_off;
  logic [1:0] mask_bit;
  seg_t       dec_seg;

  assign tick       = (cnt_q == CNT_LAST);
  assign frame_wrap = tick & (idx_q == 2'd3);
  // Masks are ordered A at bit 3, so digit k maps to bit 3-k == ~k.
  assign mask_bit   = ~idx_q;

  seg7_decode u_dec (
    .digit_i (shadow_q[idx_q]),
    .seg_o   (dec_seg)
  );

`ifdef DISP_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic [BLK_W-1:0] bcnt_q, bcnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (bcnt_q == BLK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_off = phase_q & blink_mask[mask_bit];
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blink_off    = 1'b0;
`endif

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shadow_d = load ? {D, C, B, A} : shadow_q;
    fd_d     = frame_wrap;
    // The tick edge drives one all-dark cycle so the old digit's segments
    // never flash on the newly selected anode.
    if (tick || blink_off) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = ANODE_TBL[idx_q];
      seg_d = dec_seg;
      dp_d  = ~dp_mask[mask_bit];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      an_q     <= AN_OFF;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_digit_display_scan.sv
module tb_digit_display_scan;

  localparam int DIV = 4;
  localparam int BF  = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] A, B, C, D;
  logic       load;
  logic [3:0] dp_mask, blink_mask;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  digit_display_scan #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .C(C), .D(D), .load(load),
    .dp_mask(dp_mask), .blink_mask(blink_mask),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: m_next is the 0-based count of edges since reset
  // release that the coming edge will be; everything derives from it.
  int         m_next = 0;
  logic [3:0] sh [4];
  exp_t       e_m;
  int         pos, slot, frame;
  bit         phase, blinked;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      e_m = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fd: 1'b0};
      m_next = 0;
      for (int i = 0; i < 4; i++) sh[i] = 4'd0;
    end else begin
      pos   = m_next % DIV;
      slot  = (m_next / DIV) % 4;
      frame = m_next / FRAME;
      phase = ((frame / BF) % 2) == 1;
`ifdef DISP_BLINK_EN
      blinked = phase && blink_mask[3 - slot];
`else
      blinked = 1'b0;
`endif
      if (pos == DIV - 1) begin
        e_m = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fd: (slot == 3)};
      end else if (blinked) begin
        e_m = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fd: 1'b0};
      end else begin
        e_m.an  = ~(4'b1000 >> slot);
        e_m.seg = glyph(sh[slot]);
        e_m.dp  = ~dp_mask[3 - slot];
        e_m.fd  = 1'b0;
      end
      m_next++;
      if (load) begin
        sh[0] = A; sh[1] = B; sh[2] = C; sh[3] = D;
      end
    end
    exp_q.push_back(e_m);
  end

  // Monitor: compares every registered output word against the queue.
  exp_t got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = '{an: an, seg: seg, dp: dp, fd: frame_done};
      checks++;
      if (got !== want) begin
        failures++;
        if (failures <= 40)
          $display("FAIL outputs cyc=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                   cyc, got.an, got.seg, got.dp, got.fd, want.an, want.seg, want.dp, want.fd);
      end
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load_digits(input logic [3:0] a, b, c, d);
    A = a; B = b; C = c; D = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_pos(input int target, input string name);
    int n;
    n = 0;
    while ((m_next % FRAME) != target && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((m_next % FRAME) != target) begin
      failures++;
      $display("FAIL %s: scan position %0d never reached, at %0d", name, target, m_next % FRAME);
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0;
    A = 4'd0; B = 4'd0; C = 4'd0; D = 4'd0;
    dp_mask = 4'b0000; blink_mask = 4'b0000;
    run(3);
    @(negedge clk);
    reset = 1'b1;

    load_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run(2 * FRAME);

    dp_mask = 4'b1010;
    load_digits(4'd1, 4'd2, 4'd12, 4'd4);
    run(2 * FRAME);

    // Load lands on the tick edge that ends A's slot.
    wait_pos(DIV - 1, "load_on_tick");
    load_digits(4'd1, 4'd7, 4'd12, 4'd4);
    run(FRAME);

    blink_mask = 4'b0010;
    dp_mask = 4'b0001;
    run(FRAME * BF * 4);
    blink_mask = 4'b0000;

    // Reset pulse during D's slot.
    wait_pos(3 * DIV, "reset_mid_frame");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run(2 * FRAME);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
      if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blink_mask = 4'($urandom);
      reset = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    reset = 1'b1; load = 1'b0;
    run(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
